ahb_ram_slave: RTL and testbench

//   AHB-Lite subordinate fronting a word-organised on-chip RAM; the responder for transfers issued by ahb_master.

---
 rtl/ahb_ram_slave.sv | 144 ++++++++++++++
 tb/tb_ahb_ram_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ram_slave.sv
// AHB-Lite subordinate in front of a word-organised on-chip RAM.
// Programmable wait states before each OKAY completion; two-cycle ERROR response for
// out-of-range, misaligned or oversized accesses.
module ahb_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Keep at least one counter bit so the zero-wait build still elaborates.
    localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    // 33 bits so a window ending at the top of the address space does not overflow.
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          write_q, write_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic [31:0]   off;
    logic          in_range;
    logic          misalign;
    logic          acc_err;
    state_e        acc_state;
    logic [AW-1:0] idx;
    logic [3:0]    be;

    // Address-phase decode: only NONSEQ/SEQ with the bus ready and this slave selected.
    assign accept    = hsel & hready & ((htrans == 2'b10) | (htrans == 2'b11));
    assign off       = haddr - BASE_ADDR;
    assign in_range  = (haddr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign misalign  = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    assign acc_err   = !in_range || (hsize > 3'd2) || misalign;
    assign acc_state = acc_err ? StErr1 : ((WAIT_STATES > 0) ? StWait : StData);

    // BASE_ADDR is window-aligned, so the low bits of the offset are the word index.
    assign idx = AW'((addr_q - BASE_ADDR) >> 2);

    // Byte-lane enables for the latched transfer, little-endian.
    always_comb begin
        be = 4'b0000;
        unique case (size_q)
            3'd0:    be = 4'b0001 << addr_q[1:0];
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // State and address-phase register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE/DATA/ERR2, count waits, fixed two-cycle error.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StData, StErr2: begin
                if (accept) begin
                    state_d = acc_state;
                    addr_d  = haddr;
                    size_d  = hsize;
                    write_d = hwrite;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CW'(1);
                if (32'(cnt_q) + 32'd1 == 32'(WAIT_STATES)) begin
                    state_d = StData;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // RAM write at the end of a write DATA cycle; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if ((state_q == StData) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Outputs decoded from the current state; read data is combinational from the array.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        unique case (state_q)
            StWait: hreadyout = 1'b0;
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            StErr2: hresp = 1'b1;
            StData: if (!write_q) hrdata = mem[idx];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Scoreboard bench for ahb_ram_slave: the driver computes each accepted transfer's expected
// response from a byte-level memory model and queues it; the monitor pops on completion.
module tb_ahb_ram_slave;

    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 64;
    localparam int          WS    = 3;
    localparam int          SPAN  = DEPTH * 4;

    logic        clk;
    logic        nrst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        hready_kill;

    assign hready = hreadyout & ~hready_kill;

    ahb_ram_slave #(
        .BASE_ADDR  (BASE),
        .DEPTH      (DEPTH),
        .WAIT_STATES(WS)
    ) u_dut (
        .clk      (clk),
        .nrst     (nrst),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hwdata   (hwdata),
        .hready   (hready),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .hrdata   (hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        bit          is_read;
        logic [31:0] rdata;
        int          lows;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp;
    int          n_fail;
    logic [31:0] mdl [DEPTH];
    bit          mon_en;
    logic [31:0] pend_wdata;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference rules: window, size and alignment.
    function automatic bit is_err(logic [31:0] a, logic [2:0] sz);
        longint o;
        o = longint'(a) - longint'(BASE);
        if (o < 0 || o >= SPAN) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        if (sz == 3'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 3'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_write(logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        int w;
        int nbytes;
        int first;
        w      = int'((a - BASE) / 4);
        nbytes = 1 << sz;
        first  = int'(a % 4);
        for (int k = 0; k < nbytes; k++) begin
            mdl[w][8*(first+k) +: 8] = wd[8*(first+k) +: 8];
        end
    endfunction

    // Monitor: one sample per cycle, after the driver's negedge updates have settled.
    initial begin
        bit   in_data;
        int   lows;
        exp_t e;
        in_data = 1'b0;
        lows    = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) begin
                in_data = 1'b0;
                lows    = 0;
            end else begin
                if (in_data) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_data_phase: got a data phase, expected none");
                        in_data = 1'b0;
                    end else begin
                        e = sb_q[0];
                        if (!hreadyout) begin
                            lows++;
                            check("stall_hresp", 32'(hresp), 32'(e.err));
                            check("stall_hrdata", hrdata, 32'h0);
                        end else begin
                            check("done_hresp", 32'(hresp), 32'(e.err));
                            check("stall_cycles", 32'(lows), 32'(e.lows));
                            check("done_hrdata", hrdata,
                                  (e.is_read && !e.err) ? e.rdata : 32'h0);
                            void'(sb_q.pop_front());
                            in_data = 1'b0;
                            lows    = 0;
                        end
                    end
                end else begin
                    check("idle_hreadyout", 32'(hreadyout), 32'h1);
                    check("idle_hresp", 32'(hresp), 32'h0);
                    check("idle_hrdata", hrdata, 32'h0);
                end
                if (hsel && hready && htrans[1]) in_data = 1'b1;
            end
        end
    end

    // Drive one address phase; junk is driven while the slave stalls the bus.
    task automatic issue(input bit sel, input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input bit kill);
        int   guard;
        exp_t e;
        @(negedge clk);
        hwdata      = pend_wdata;
        hready_kill = 1'b0;
        guard       = 0;
        while (!hreadyout) begin
            hsel   = 1'b1;
            htrans = 2'b10;
            haddr  = $urandom;
            hwrite = 1'($urandom_range(0, 1));
            hsize  = 3'($urandom_range(0, 2));
            @(negedge clk);
            guard++;
            if (guard > 64) begin
                $display("FAIL driver_timeout: got hreadyout low for %0d cycles, expected <= %0d",
                         guard, WS);
                $fatal(1, "hreadyout stuck low");
            end
        end
        hsel        = sel;
        htrans      = tr;
        hwrite      = wr;
        hsize       = sz;
        haddr       = a;
        hready_kill = kill;
        pend_wdata  = $urandom;
        if (sel && !kill && tr[1]) begin
            e.err     = is_err(a, sz);
            e.is_read = !wr;
            e.lows    = e.err ? 1 : WS;
            e.rdata   = 32'h0;
            if (!e.err) begin
                if (wr) model_write(a, sz, wd);
                else e.rdata = mdl[int'((a - BASE) / 4)];
            end
            sb_q.push_back(e);
            if (wr) pend_wdata = wd;
        end
    endtask

    task automatic idle();
        issue(1'b1, 2'b00, 1'b0, 3'd0, BASE, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] old;
        logic [2:0]  rsz;
        int          r;
        n_cmp       = 0;
        n_fail      = 0;
        mon_en      = 1'b1;
        nrst        = 1'b0;
        hsel        = 1'b0;
        haddr       = '0;
        htrans      = 2'b00;
        hwrite      = 1'b0;
        hsize       = 3'd0;
        hwdata      = '0;
        hready_kill = 1'b0;
        pend_wdata  = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        // Give every word a known value.
        for (int w = 0; w < DEPTH; w++) begin
            issue(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'(4 * w), $urandom, 1'b0);
        end
        repeat (3) idle();
        repeat (2) @(negedge clk);

        // Reset in the middle of a write's wait states: the write must be dropped.
        old    = mdl[8];
        mon_en = 1'b0;
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'd2;
        haddr  = BASE + 32'h20;
        @(negedge clk);
        hwdata = ~old;
        htrans = 2'b00;
        #1;
        check("pre_reset_stall", 32'(hreadyout), 32'h0);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("reset_hreadyout", 32'(hreadyout), 32'h1);
        check("reset_hresp", 32'(hresp), 32'h0);
        check("reset_hrdata", hrdata, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        sb_q.delete();
        pend_wdata = '0;
        @(negedge clk);
        mon_en = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h20, 32'h0, 1'b0);
        idle();

        // Back-to-back word write then read.
        issue(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 32'h0, 1'b0);
        idle();

        // Byte and half writes over a known word.
        issue(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h10, 32'h0123_4567, 1'b0);
        issue(1'b1, 2'b11, 1'b1, 3'd0, BASE + 32'h11, 32'h0000_AA00, 1'b0);
        issue(1'b1, 2'b11, 1'b0, 3'd2, BASE + 32'h10, 32'h0, 1'b0);
        issue(1'b1, 2'b10, 1'b1, 3'd1, BASE + 32'h12, 32'hBEEF_0000, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 32'h0, 1'b0);
        idle();

        // Error responses, then confirm nothing changed.
        issue(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'(SPAN), 32'h0, 1'b0);
        issue(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h2, 32'hFFFF_FFFF, 1'b0);
        issue(1'b1, 2'b10, 1'b1, 3'd3, BASE, 32'hFFFF_FFFF, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 3'd2, BASE, 32'h0, 1'b0);
        idle();

        // Transfers that must not be accepted.
        issue(1'b1, 2'b01, 1'b1, 3'd2, BASE + 32'h4, 32'h1111_1111, 1'b0);
        issue(1'b1, 2'b00, 1'b1, 3'd2, BASE + 32'h4, 32'h2222_2222, 1'b0);
        issue(1'b0, 2'b10, 1'b1, 3'd2, BASE + 32'h4, 32'h3333_3333, 1'b0);
        issue(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h4, 32'h4444_4444, 1'b1);
        idle();
        issue(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h4, 32'h0, 1'b0);
        idle();

        // Randomised mix.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85) ra = BASE + 32'($urandom_range(0, SPAN - 1));
            else if (r < 92) ra = BASE - 32'd1 - 32'($urandom_range(0, 15));
            else ra = BASE + 32'(SPAN) + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 9) rsz = 3'($urandom_range(0, 2));
            else rsz = 3'($urandom_range(3, 7));
            if (rsz <= 3'd2 && $urandom_range(0, 9) < 7) ra = ra & ~((32'd1 << rsz) - 32'd1);
            r = int'($urandom_range(0, 99));
            if (r < 80) issue(1'b1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), rsz, ra,
                              $urandom, 1'b0);
            else if (r < 90) issue(1'b1, 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rsz,
                                   ra, $urandom, 1'b0);
            else if (r < 95) issue(1'b0, 2'b10, 1'($urandom_range(0, 1)), rsz, ra, $urandom, 1'b0);
            else issue(1'b1, 2'b10, 1'($urandom_range(0, 1)), rsz, ra, $urandom, 1'b1);
        end
        repeat (2) idle();
        repeat (WS + 4) @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
